clock_ctrl: RTL and testbench

- Time-keeping controller that sequences a cascaded seconds/minutes/hours counter chain (mod-60, mod-60, mod-24) from a single system clock.
- Contains a tick prescaler, a 3-state mode FSM (RUN / SET_HOUR / SET_MIN) and the carry sequencing between stages.
- Feeds the display/BCD path and any downstream day-count logic via day_carry.

---
 rtl/clock_ctrl_if.sv | 34 +++
 rtl/clock_ctrl.sv | 104 ++++++++++
 tb/tb_clock_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/clock_ctrl_if.sv
// Button inputs and time/status outputs of the clock controller.
// The slave modport is the controller side; the master modport drives the buttons.
interface clock_ctrl_if;
   logic       mode_btn;
   logic       inc_btn;
   logic [4:0] hour_out;
   logic [5:0] min_out;
   logic [5:0] sec_out;
   logic [1:0] state_out;
   logic       sec_tick;
   logic       day_carry;

   modport master (
      output mode_btn,
      output inc_btn,
      input  hour_out,
      input  min_out,
      input  sec_out,
      input  state_out,
      input  sec_tick,
      input  day_carry
   );

   modport slave (
      input  mode_btn,
      input  inc_btn,
      output hour_out,
      output min_out,
      output sec_out,
      output state_out,
      output sec_tick,
      output day_carry
   );
endinterface

// File: rtl/clock_ctrl.sv
// Hours/minutes/seconds time-keeper with a one-second prescaler and RUN/SET_HOUR/SET_MIN mode FSM.
// Every output is a register; counts and pulses appear the cycle after the edge that produced them.
module clock_ctrl #(
   parameter int DIV = 50000000
) (
   input  logic       clk,
   input  logic       rst,
   clock_ctrl_if.slave bus
);

   localparam int PW = $clog2(DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      SET_HOUR = 2'b01,
      SET_MIN  = 2'b10,
      ILLEGAL  = 2'b11
   } state_t;

   state_t        state;
   logic [PW-1:0] presc;
   logic [4:0]    hour;
   logic [5:0]    min;
   logic [5:0]    sec;
   logic          sec_tick_q;
   logic          day_carry_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         presc       <= '0;
         hour        <= '0;
         min         <= '0;
         sec         <= '0;
         sec_tick_q  <= 1'b0;
         day_carry_q <= 1'b0;
      end else begin
         sec_tick_q  <= 1'b0;
         day_carry_q <= 1'b0;
         case (state)
            RUN: begin
               if (bus.mode_btn) begin
                  // Leaving RUN discards a coincident tick edge and freezes the time.
                  state <= SET_HOUR;
                  presc <= '0;
               end else if (presc >= PRESC_LAST) begin
                  presc      <= '0;
                  sec_tick_q <= 1'b1;
                  if (sec >= 6'd59) begin
                     sec <= '0;
                     if (min >= 6'd59) begin
                        min <= '0;
                        if (hour >= 5'd23) begin
                           hour        <= '0;
                           day_carry_q <= 1'b1;
                        end else begin
                           hour <= hour + 5'd1;
                        end
                     end else begin
                        min <= min + 6'd1;
                     end
                  end else begin
                     sec <= sec + 6'd1;
                  end
               end else begin
                  presc <= presc + PRESC_ONE;
               end
            end
            SET_HOUR: begin
               presc <= '0;
               if (bus.mode_btn) begin
                  state <= SET_MIN;
               end else if (bus.inc_btn) begin
                  hour <= (hour >= 5'd23) ? 5'd0 : hour + 5'd1;
               end
            end
            SET_MIN: begin
               presc <= '0;
               if (bus.mode_btn) begin
                  // Resuming RUN restarts the second so the next tick is a full period away.
                  state <= RUN;
                  sec   <= '0;
               end else if (bus.inc_btn) begin
                  min <= (min >= 6'd59) ? 6'd0 : min + 6'd1;
               end
            end
            default: begin
               state <= RUN;
               presc <= '0;
            end
         endcase
      end
   end

   assign bus.hour_out  = hour;
   assign bus.min_out   = min;
   assign bus.sec_out   = sec;
   assign bus.state_out = state;
   assign bus.sec_tick  = sec_tick_q;
   assign bus.day_carry = day_carry_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Directed bench for clock_ctrl with DIV=4; stimulus queues expected snapshots and ticks, a negedge monitor checks them.
module tb_clock_ctrl;

   logic clk;
   logic rst;
   int   cyc;
   int   total;
   int   bad;

   clock_ctrl_if bus ();

   clock_ctrl #(.DIV(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int          at;
      string       name;
      logic [4:0]  h;
      logic [5:0]  m;
      logic [5:0]  s;
      logic [1:0]  st;
      logic        tk;
      logic        dc;
   } exp_t;

   exp_t snap_q[$];
   exp_t tick_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic snap(input string n, input int at, input int h, input int m, input int s,
                       input int st, input bit tk, input bit dc);
      exp_t e;
      e.at = at; e.name = n; e.h = 5'(h); e.m = 6'(m); e.s = 6'(s);
      e.st = 2'(st); e.tk = tk; e.dc = dc;
      snap_q.push_back(e);
   endtask

   task automatic etick(input int at, input int h, input int m, input int s, input bit dc);
      exp_t e;
      e.at = at; e.name = "tick"; e.h = 5'(h); e.m = 6'(m); e.s = 6'(s);
      e.st = 2'd0; e.tk = 1'b1; e.dc = dc;
      tick_q.push_back(e);
   endtask

   task automatic pulse(input bit m, input bit i);
      bus.mode_btn = m;
      bus.inc_btn  = i;
      @(posedge clk);
      #1;
      bus.mode_btn = 1'b0;
      bus.inc_btn  = 1'b0;
   endtask

   task automatic idle_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic bit same(input exp_t e);
      return bus.hour_out == e.h && bus.min_out == e.m && bus.sec_out == e.s &&
             bus.state_out == e.st && bus.sec_tick == e.tk && bus.day_carry == e.dc;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (tick_q.size() > 0 && tick_q[0].at < cyc) begin
         e = tick_q.pop_front();
         total++; bad++;
         $display("FAIL missing_tick cyc=%0d expected at %0d time %0d:%0d:%0d", cyc, e.at, e.h, e.m, e.s);
      end
      if (bus.sec_tick) begin
         total++;
         if (tick_q.size() == 0 || tick_q[0].at != cyc) begin
            bad++;
            $display("FAIL unexpected_tick cyc=%0d got %0d:%0d:%0d st=%0d", cyc,
                     bus.hour_out, bus.min_out, bus.sec_out, bus.state_out);
         end else begin
            e = tick_q.pop_front();
            if (!same(e)) begin
               bad++;
               $display("FAIL tick cyc=%0d got %0d:%0d:%0d st=%0d dc=%0d want %0d:%0d:%0d st=%0d dc=%0d",
                        cyc, bus.hour_out, bus.min_out, bus.sec_out, bus.state_out, bus.day_carry,
                        e.h, e.m, e.s, e.st, e.dc);
            end
         end
      end else if (bus.day_carry) begin
         total++; bad++;
         $display("FAIL stray_day_carry cyc=%0d got day_carry=1 want 0", cyc);
      end
      while (snap_q.size() > 0 && snap_q[0].at <= cyc) begin
         e = snap_q.pop_front();
         total++;
         if (e.at < cyc) begin
            bad++;
            $display("FAIL %s missed check cyc=%0d scheduled %0d", e.name, cyc, e.at);
         end else if (!same(e)) begin
            bad++;
            $display("FAIL %s cyc=%0d got %0d:%0d:%0d st=%0d tk=%0d dc=%0d want %0d:%0d:%0d st=%0d tk=%0d dc=%0d",
                     e.name, cyc, bus.hour_out, bus.min_out, bus.sec_out, bus.state_out,
                     bus.sec_tick, bus.day_carry, e.h, e.m, e.s, e.st, e.tk, e.dc);
         end
      end
   end

   initial begin
      int r, e_run, x, y, z, w;
      cyc = 0; total = 0; bad = 0;
      rst = 1'b1;
      bus.mode_btn = 1'b0;
      bus.inc_btn  = 1'b0;

      // Reset release and first tick four edges later.
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      r = cyc;
      snap("reset", r, 0, 0, 0, 0, 0, 0);
      snap("pre_first_tick", r + 3, 0, 0, 0, 0, 0, 0);
      etick(r + 4, 0, 0, 1, 0);
      idle_to(r + 4);

      // Set 23:59 and run across the day wrap.
      pulse(1, 0);
      snap("enter_set_hour", cyc, 0, 0, 1, 1, 0, 0);
      repeat (23) pulse(0, 1);
      snap("hour_23", cyc, 23, 0, 1, 1, 0, 0);
      pulse(1, 0);
      snap("enter_set_min", cyc, 23, 0, 1, 2, 0, 0);
      repeat (59) pulse(0, 1);
      snap("min_59", cyc, 23, 59, 1, 2, 0, 0);
      pulse(1, 0);
      e_run = cyc;
      snap("exit_to_run", e_run, 23, 59, 0, 0, 0, 0);
      for (int k = 1; k < 60; k++) etick(e_run + 4 * k, 23, 59, k, 0);
      etick(e_run + 240, 0, 0, 0, 1);
      snap("after_wrap", e_run + 241, 0, 0, 0, 0, 0, 0);
      idle_to(e_run + 241);

      // Field wrap in the set modes, no carry between fields.
      pulse(1, 0);
      snap("set_hour_from_zero", cyc, 0, 0, 0, 1, 0, 0);
      repeat (25) pulse(0, 1);
      snap("hour_inc25", cyc, 1, 0, 0, 1, 0, 0);
      pulse(1, 0);
      repeat (61) pulse(0, 1);
      snap("min_inc61", cyc, 1, 1, 0, 2, 0, 0);

      // mode and inc together: mode wins.
      pulse(1, 0);
      x = cyc;
      snap("back_to_run", x, 1, 1, 0, 0, 0, 0);
      pulse(1, 0);
      snap("set_hour_again", cyc, 1, 1, 0, 1, 0, 0);
      pulse(1, 1);
      snap("mode_inc_same", cyc, 1, 1, 0, 2, 0, 0);
      pulse(1, 0);
      y = cyc;
      snap("run_again", y, 1, 1, 0, 0, 0, 0);

      // Five ticks, then leave RUN exactly on the sixth tick edge.
      for (int k = 1; k <= 5; k++) etick(y + 4 * k, 1, 1, k, 0);
      idle_to(y + 23);
      pulse(1, 0);
      snap("tick_discarded", y + 24, 1, 1, 5, 1, 0, 0);
      idle_to(cyc + 100);
      snap("frozen_100", cyc, 1, 1, 5, 1, 0, 0);
      pulse(1, 0);
      pulse(1, 0);
      z = cyc;
      snap("reenter_run", z, 1, 1, 0, 0, 0, 0);
      snap("reenter_pre_tick", z + 3, 1, 1, 0, 0, 0, 0);
      etick(z + 4, 1, 1, 1, 0);
      idle_to(z + 4);

      // Reset during SET_MIN with inc pulsed at the same time.
      pulse(1, 0);
      repeat (6) pulse(0, 1);
      pulse(1, 0);
      snap("hour_7", cyc, 7, 1, 1, 2, 0, 0);
      rst = 1'b1;
      bus.inc_btn = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.inc_btn = 1'b0;
      w = cyc;
      snap("mid_set_reset", w, 0, 0, 0, 0, 0, 0);
      pulse(0, 1);
      snap("inc_ignored_in_run", w + 1, 0, 0, 0, 0, 0, 0);
      etick(w + 4, 0, 0, 1, 0);
      idle_to(w + 6);
      @(negedge clk);
      #1;

      total++;
      if (snap_q.size() != 0 || tick_q.size() != 0) begin
         bad++;
         $display("FAIL leftover_expectations got snaps=%0d ticks=%0d want 0 and 0",
                  snap_q.size(), tick_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
